// File: rtl/sa_gemm_core_if.sv
// Job/stream interface of the systolic GEMM core: configuration and start,
// operand beat handshake, status and the result array.
interface sa_gemm_core_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int WDATA = 8,
    parameter int WACC  = 2*WDATA+4,
    parameter int KMAX  = 16
);
    localparam int KW = $clog2(KMAX+1);
    localparam int RW = $clog2(ROWS)+1;
    localparam int CW = $clog2(COLS)+1;

    logic                                  start;
    logic [RW-1:0]                         row_cfg;
    logic [CW-1:0]                         col_cfg;
    logic [KW-1:0]                         k_len;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [ROWS-1:0][WDATA-1:0]            a_in;
    logic [COLS-1:0][WDATA-1:0]            b_in;
    logic                                  busy;
    logic                                  done;
    logic                                  out_valid;
    logic [ROWS-1:0][COLS-1:0][WACC-1:0]   c_out;

    // Job issuer / operand source side.
    modport master (
        output start, row_cfg, col_cfg, k_len, in_valid, a_in, b_in,
        input  in_ready, busy, done, out_valid, c_out
    );

    // Core side.
    modport slave (
        input  start, row_cfg, col_cfg, k_len, in_valid, a_in, b_in,
        output in_ready, busy, done, out_valid, c_out
    );
endinterface

// File: rtl/sa_gemm_core.sv
// Output-stationary ROWS x COLS systolic GEMM core. Each accepted beat carries
// one column of A and one row of B; skew is applied internally, operands flow
// east (A) and south (B), and every PE keeps its own accumulator.
// Optional feature: define SA_SATURATE_EN to saturate accumulators instead of
// letting them wrap modulo 2^WACC.
module sa_gemm_core #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int WDATA = 8,
    parameter int WACC  = 2*WDATA+4,
    parameter int KMAX  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    sa_gemm_core_if.slave bus
);
    localparam int KW = $clog2(KMAX+1);
    localparam int RW = $clog2(ROWS)+1;
    localparam int CW = $clog2(COLS)+1;
    localparam int DW = $clog2(ROWS+COLS)+1;
    localparam int PW = 2*WDATA;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [RW-1:0] ar;
    logic [RW-1:0] row_clamp;
    logic [CW-1:0] ac;
    logic [CW-1:0] col_clamp;
    logic [KW-1:0] k_lat;
    logic [KW-1:0] beat_cnt;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_last;
    logic          done_q;
    logic          out_valid_q;
    logic          start_ok;
    logic          accept;

    logic [ROWS-1:0] row_act;
    logic [COLS-1:0] col_act;

    logic signed [WDATA-1:0] a_feed  [ROWS];
    logic signed [WDATA-1:0] a_edge  [ROWS];
    logic signed [WDATA-1:0] b_feed  [COLS];
    logic signed [WDATA-1:0] b_edge  [COLS];
    logic signed [WDATA-1:0] a_east  [ROWS][COLS];
    logic signed [WDATA-1:0] b_south [ROWS][COLS];

    assign start_ok   = bus.start && (state == S_IDLE);
    assign accept     = bus.in_valid && (state == S_LOAD);
    assign drain_last = DW'(ar) + DW'(ac) - DW'(2);

    assign bus.in_ready  = (state == S_LOAD);
    assign bus.busy      = (state == S_LOAD) || (state == S_DRAIN);
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;

    // Clamp out-of-range shape requests to the full physical array.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        row_clamp = bus.row_cfg;
        col_clamp = bus.col_cfg;
        if (bus.row_cfg == '0 || bus.row_cfg > RW'(ROWS)) row_clamp = RW'(ROWS);
        if (bus.col_cfg == '0 || bus.col_cfg > CW'(COLS)) col_clamp = CW'(COLS);
    end

    // Active-region masks derived from the latched shape.
    always_comb begin
        for (int i = 0; i < ROWS; i++) row_act[i] = (RW'(i) < ar);
        for (int j = 0; j < COLS; j++) col_act[j] = (CW'(j) < ac);
    end

    // Job sequencing: IDLE -> LOAD (k_len beats) -> DRAIN (ar+ac-1 cycles).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ar          <= RW'(ROWS);
            ac          <= CW'(COLS);
            k_lat       <= '0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        ar        <= row_clamp;
                        ac        <= col_clamp;
                        k_lat     <= bus.k_len;
                        beat_cnt  <= '0;
                        drain_cnt <= '0;
                        if (bus.k_len == '0) begin
                            done_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else begin
                            out_valid_q <= 1'b0;
                            state       <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if (beat_cnt + KW'(1) == k_lat) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == drain_last) begin
                        state       <= S_IDLE;
                        done_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand injection: zeros on idle cycles and for inactive rows/columns.
    always_comb begin
        for (int i = 0; i < ROWS; i++)
            a_feed[i] = (accept && row_act[i]) ? $signed(bus.a_in[i]) : '0;
        for (int j = 0; j < COLS; j++)
            b_feed[j] = (accept && col_act[j]) ? $signed(bus.b_in[j]) : '0;
    end

    // Row skew: a_in[i] reaches column 0 after i register stages.
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        if (i == 0) begin : g_direct
            assign a_edge[i] = a_feed[i];
        end else begin : g_delay
            logic signed [WDATA-1:0] dly [i];

            // Shift the row operand one stage per cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    // NOTE: the delay line is a small register array, not a
                    // RAM, so every entry is cleared by reset.
                    for (int d = 0; d < i; d++) dly[d] <= '0;
                end else begin
                    dly[0] <= a_feed[i];
                    for (int d = 1; d < i; d++) dly[d] <= dly[d-1];
                end
            end

            assign a_edge[i] = dly[i-1];
        end
    end

    // Column skew: b_in[j] reaches row 0 after j register stages.
    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        if (j == 0) begin : g_direct
            assign b_edge[j] = b_feed[j];
        end else begin : g_delay
            logic signed [WDATA-1:0] dly [j];

            // Shift the column operand one stage per cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d < j; d++) dly[d] <= '0;
                end else begin
                    dly[0] <= b_feed[j];
                    for (int d = 1; d < j; d++) dly[d] <= dly[d-1];
                end
            end

            assign b_edge[j] = dly[j-1];
        end
    end

    // Processing element array.
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic signed [WDATA-1:0] a_src;
            logic signed [WDATA-1:0] b_src;
            logic signed [WDATA-1:0] a_op;
            logic signed [WDATA-1:0] b_op;
            logic signed [WDATA-1:0] a_q;
            logic signed [WDATA-1:0] b_q;
            logic signed [PW-1:0]    prod;
            logic signed [WACC-1:0]  prod_x;
            logic signed [WACC-1:0]  acc_q;
            logic signed [WACC-1:0]  acc_next;
            logic                    pe_act;

            if (j == 0) begin : g_a_first
                assign a_src = a_edge[i];
            end else begin : g_a_link
                assign a_src = a_east[i][j-1];
            end

            if (i == 0) begin : g_b_first
                assign b_src = b_edge[j];
            end else begin : g_b_link
                assign b_src = b_south[i-1][j];
            end

            assign pe_act = row_act[i] && col_act[j];
            assign a_op   = pe_act ? a_src : '0;
            assign b_op   = pe_act ? b_src : '0;
            assign prod   = PW'(a_op) * PW'(b_op);
            assign prod_x = WACC'(prod);

`ifdef SA_SATURATE_EN
            logic signed [WACC:0] sum_w;

            // Saturating accumulate: clip on signed overflow of the WACC sum.
            always_comb begin
                sum_w    = (WACC+1)'(acc_q) + (WACC+1)'(prod_x);
                acc_next = sum_w[WACC-1:0];
                if (sum_w[WACC] != sum_w[WACC-1])
                    acc_next = sum_w[WACC] ? {1'b1, {(WACC-1){1'b0}}}
                                           : {1'b0, {(WACC-1){1'b1}}};
            end
`else
            // Wrapping accumulate modulo 2^WACC.
            always_comb begin
                acc_next = acc_q + prod_x;
            end
`endif

            // Forward operands east/south and update the accumulator.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q <= a_op;
                    b_q <= b_op;
                    if (start_ok || !pe_act) acc_q <= '0;
                    else                     acc_q <= acc_next;
                end
            end

            assign a_east[i][j]    = a_q;
            assign b_south[i][j]   = b_q;
            assign bus.c_out[i][j] = acc_q;
        end
    end

endmodule

// File: tb/tb_sa_gemm_core.sv
// Directed bench for sa_gemm_core: identity, partial shape, bubbles, k_len=0,
// clamping, asynchronous reset mid-job and accumulator overflow behaviour
// (expectation follows SA_SATURATE_EN when the bench is built with it).
module tb_sa_gemm_core;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int WDATA = 8;
    localparam int WACC  = 16;
    localparam int KMAX  = 16;
    localparam int KW    = 5;
    localparam int RW    = 3;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst_n;

    int tests = 0;
    int fails = 0;
    int a_tab [KMAX][ROWS];
    int b_tab [KMAX][COLS];

    always #5 clk = ~clk;

    sa_gemm_core_if #(.ROWS(ROWS), .COLS(COLS), .WDATA(WDATA), .WACC(WACC), .KMAX(KMAX)) bus ();

    sa_gemm_core #(.ROWS(ROWS), .COLS(COLS), .WDATA(WDATA), .WACC(WACC), .KMAX(KMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic fill_identity();
        for (int t = 0; t < KMAX; t++) begin
            for (int i = 0; i < ROWS; i++) a_tab[t][i] = (i == t) ? 1 : 0;
            for (int j = 0; j < COLS; j++) b_tab[t][j] = 4*t + j + 1;
        end
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int t = 0; t < KMAX; t++) begin
            for (int i = 0; i < ROWS; i++) a_tab[t][i] = av;
            for (int j = 0; j < COLS; j++) b_tab[t][j] = bv;
        end
    endtask

    // Issues one job at posedge+1 and returns at posedge+1 one cycle after done.
    task automatic run_job(input string name, input int rc, input int cc, input int k,
                           input bit bubbles, input bit poke, input int exp_done);
        int n, beat, done_n;
        bit adv, ready_seen, valid;
        n = 0; beat = 0; done_n = -1; adv = 0; ready_seen = 0;
        bus.start    = 1'b1;
        bus.row_cfg  = RW'(rc);
        bus.col_cfg  = CW'(cc);
        bus.k_len    = KW'(k);
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 100 && done_n < 0; cyc++) begin
            @(posedge clk); #1;
            n++;
            if (adv) beat++;
            bus.start = poke && (n == 2);
            if (poke && n == 2) begin
                bus.row_cfg = RW'(1);
                bus.k_len   = KW'(0);
            end
            if (bus.in_ready) ready_seen = 1;
            if (n == 1) begin
                tests++;
                if (bus.out_valid !== (k == 0)) begin
                    fails++;
                    $display("FAIL %s out_valid_cycle1: got %b, want %b", name, bus.out_valid, k == 0);
                end
                tests++;
                if (bus.busy !== (k != 0)) begin
                    fails++;
                    $display("FAIL %s busy_cycle1: got %b, want %b", name, bus.busy, k != 0);
                end
            end
            if (bus.done) begin
                done_n = n;
                tests++;
                if (bus.out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL %s out_valid_at_done: got %b, want 1", name, bus.out_valid);
                end
            end else begin
                valid = (beat < k) && !(bubbles && (n % 2 == 0));
                bus.in_valid = valid;
                for (int i = 0; i < ROWS; i++)
                    if (valid) bus.a_in[i] = WDATA'(a_tab[beat][i]); else bus.a_in[i] = 8'h5A;
                for (int j = 0; j < COLS; j++)
                    if (valid) bus.b_in[j] = WDATA'(b_tab[beat][j]); else bus.b_in[j] = 8'hA5;
                adv = valid && bus.in_ready;
            end
        end
        bus.in_valid = 1'b0;
        tests++;
        if (done_n != exp_done) begin
            fails++;
            $display("FAIL %s done_cycle: got %0d, want %0d", name, done_n, exp_done);
        end
        if (k == 0) begin
            tests++;
            if (ready_seen) begin
                fails++;
                $display("FAIL %s in_ready_seen: got 1, want 0", name);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (bus.done !== 1'b0 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s after_done: got done=%b out_valid=%b, want done=0 out_valid=1",
                     name, bus.done, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.start = 1'b0; bus.row_cfg = '0; bus.col_cfg = '0; bus.k_len = '0;
        bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0;
        #1 rst_n = 1'b0;
        #2;
        tests++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: got rdy=%b busy=%b done=%b ov=%b, want all 0",
                     bus.in_ready, bus.busy, bus.done, bus.out_valid);
        end
        tests++;
        if (bus.c_out !== '0) begin
            fails++;
            $display("FAIL reset_c_out: got %h, want 0", bus.c_out);
        end
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got rdy=%b busy=%b, want 0 0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_identity();
        logic signed [WACC-1:0] got;
        fill_identity();
        run_job("identity", 4, 4, 4, 0, 0, 12);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                got = bus.c_out[i][j];
                tests++;
                if (got !== WACC'(4*i + j + 1)) begin
                    fails++;
                    $display("FAIL identity c[%0d][%0d]: got %0d, want %0d", i, j, got, 4*i + j + 1);
                end
            end
        repeat (3) @(posedge clk);
        #1;
        got = bus.c_out[3][3];
        tests++;
        if (bus.out_valid !== 1'b1 || got !== WACC'(16)) begin
            fails++;
            $display("FAIL identity_hold: got out_valid=%b c[3][3]=%0d, want 1 16", bus.out_valid, got);
        end
    endtask

    task automatic test_partial();
        logic signed [WACC-1:0] got;
        int exp;
        fill_const(1, 1);
        run_job("partial", 2, 3, 5, 0, 1, 10);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                got = bus.c_out[i][j];
                exp = (i < 2 && j < 3) ? 5 : 0;
                tests++;
                if (got !== WACC'(exp)) begin
                    fails++;
                    $display("FAIL partial c[%0d][%0d]: got %0d, want %0d", i, j, got, exp);
                end
            end
    endtask

    task automatic test_bubbles();
        logic signed [WACC-1:0] got;
        fill_identity();
        run_job("bubbles", 4, 4, 4, 1, 0, 15);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                got = bus.c_out[i][j];
                tests++;
                if (got !== WACC'(4*i + j + 1)) begin
                    fails++;
                    $display("FAIL bubbles c[%0d][%0d]: got %0d, want %0d", i, j, got, 4*i + j + 1);
                end
            end
    endtask

    task automatic test_zero_k();
        run_job("zero_k", 4, 4, 0, 0, 0, 1);
        tests++;
        if (bus.c_out !== '0) begin
            fails++;
            $display("FAIL zero_k c_out: got %h, want 0", bus.c_out);
        end
    endtask

    task automatic test_clamp();
        logic signed [WACC-1:0] got;
        fill_const(1, 1);
        run_job("clamp", 0, 7, 1, 0, 0, 9);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                got = bus.c_out[i][j];
                tests++;
                if (got !== WACC'(1)) begin
                    fails++;
                    $display("FAIL clamp c[%0d][%0d]: got %0d, want 1", i, j, got);
                end
            end
    endtask

    task automatic test_async_reset();
        logic signed [WACC-1:0] got;
        int done_seen;
        int exp;
        fill_identity();
        bus.start = 1'b1; bus.row_cfg = RW'(4); bus.col_cfg = CW'(4); bus.k_len = KW'(4);
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
            bus.start    = 1'b0;
            bus.in_valid = 1'b1;
            for (int i = 0; i < ROWS; i++) bus.a_in[i] = WDATA'(a_tab[n-1][i]);
            for (int j = 0; j < COLS; j++) bus.b_in[j] = WDATA'(b_tab[n-1][j]);
        end
        got = bus.c_out[0][0];
        tests++;
        if (bus.busy !== 1'b1 || got !== WACC'(1)) begin
            fails++;
            $display("FAIL pre_reset: got busy=%b c[0][0]=%0d, want 1 1", bus.busy, got);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.out_valid !== 1'b0 || bus.c_out !== '0) begin
            fails++;
            $display("FAIL async_reset: got rdy=%b busy=%b done=%b ov=%b c=%h, want all 0",
                     bus.in_ready, bus.busy, bus.done, bus.out_valid, bus.c_out);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #4 rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (bus.done) done_seen++;
        end
        tests++;
        if (done_seen != 0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abandoned_job: got done_pulses=%0d out_valid=%b, want 0 0", done_seen, bus.out_valid);
        end
        fill_const(2, 3);
        run_job("post_reset", 2, 3, 1, 0, 0, 6);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                got = bus.c_out[i][j];
                exp = (i < 2 && j < 3) ? 6 : 0;
                tests++;
                if (got !== WACC'(exp)) begin
                    fails++;
                    $display("FAIL post_reset c[%0d][%0d]: got %0d, want %0d", i, j, got, exp);
                end
            end
    endtask

    task automatic test_overflow();
        logic signed [WACC-1:0] got;
        int exp;
`ifdef SA_SATURATE_EN
        exp = 32767;
`else
        exp = -17149;
`endif
        fill_const(127, 127);
        run_job("overflow", 4, 4, 3, 0, 0, 11);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                got = bus.c_out[i][j];
                tests++;
                if (got !== WACC'(exp)) begin
                    fails++;
                    $display("FAIL overflow c[%0d][%0d]: got %0d, want %0d", i, j, got, exp);
                end
            end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_partial();
        test_bubbles();
        test_zero_k();
        test_clamp();
        test_async_reset();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sa_gemm_core.md
SA_GEMM_CORE -- requirements
Module: sa_gemm_core

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, meaning the physical PE row count.
REQ-002 The block SHALL have parameter COLS, default 4, meaning the physical PE column count.
REQ-003 The block SHALL have parameter WDATA, default 8, meaning the signed operand width.
REQ-004 The block SHALL have parameter WACC, default 2*WDATA+4, meaning the signed accumulator width.
REQ-005 The block SHALL have parameter KMAX, default 16, meaning the maximum reduction length; KW = $clog2(KMAX+1).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-008 The block SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-009 The block SHALL have port row_cfg, input, $clog2(ROWS)+1 bits: active rows, latched on start.
REQ-010 The block SHALL have port col_cfg, input, $clog2(COLS)+1 bits: active columns, latched on start.
REQ-011 The block SHALL have port k_len, input, KW bits: beats per job, latched on start.
REQ-012 The block SHALL have port in_valid, input, 1 bit: a_in/b_in carry a beat.
REQ-013 The block SHALL have port in_ready, output, 1 bit: the core accepts a beat.
REQ-014 The block SHALL have port a_in, input, ROWS x WDATA: one unskewed column of A.
REQ-015 The block SHALL have port b_in, input, COLS x WDATA: one unskewed row of B.
REQ-016 The block SHALL have port busy, output, 1 bit: high in LOAD or DRAIN.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle job-complete pulse.
REQ-018 The block SHALL have port out_valid, output, 1 bit: c_out holds a finished result.
REQ-019 The block SHALL have port c_out, output, ROWS x COLS x WACC: the accumulator array.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD and DRAIN, and SHALL go IDLE->LOAD on start in IDLE when k_len is nonzero.
REQ-021 Start in IDLE SHALL latch the configuration, clear all accumulators, clear out_valid, and reset the beat and drain counters.
REQ-022 Start outside IDLE SHALL be ignored.
REQ-023 A latched row_cfg or col_cfg of 0, or one greater than ROWS/COLS, SHALL be clamped to ROWS/COLS respectively (ar, ac).
REQ-024 in_ready SHALL be 1 only in LOAD, and a beat SHALL be accepted when in_valid and in_ready are both high.
REQ-025 LOAD->DRAIN SHALL occur on acceptance of beat k_len.
REQ-026 Cycles without an accepted beat SHALL inject zero operands.
REQ-027 Skew SHALL be internal: a_in[i] delayed i cycles, b_in[j] delayed j cycles; each PE registers its operands east/south.
REQ-028 Each PE(i,j) SHALL perform acc += a*b, signed, at full product width, sign-extended to WACC.
REQ-029 A PE with i >= ar or j >= ac SHALL have its operands forced to zero and its accumulator held at 0.
REQ-030 DRAIN SHALL last ar+ac-1 cycles, then go DRAIN->IDLE; on the final cycle done SHALL pulse and out_valid SHALL be set.
REQ-031 With no bubbles and start accepted at cycle 0, done SHALL assert at cycle k_len+ar+ac.
REQ-032 Each bubble SHALL delay done by one cycle.
REQ-033 Start with k_len = 0 SHALL skip LOAD/DRAIN; done and out_valid SHALL assert the next cycle with c_out all zero.
REQ-034 out_valid and c_out SHALL hold until the next accepted start.

Reset
REQ-035 When rst_n is low, reset SHALL act immediately: state IDLE, all accumulators, skew and pipeline registers 0, in_ready/busy/done/out_valid 0, latched ar=ROWS, ac=COLS, k counter 0.
REQ-036 Reset mid-job SHALL abandon the job with no done pulse; the first start after rst_n rises SHALL be honoured normally.

Configuration
REQ-037 With macro SA_SATURATE_EN defined, each accumulate SHALL saturate to [-2^(WACC-1), 2^(WACC-1)-1].
REQ-038 Without SA_SATURATE_EN, each accumulate SHALL wrap modulo 2^WACC.

Verification
REQ-039 Scenario: defaults; start, k_len=4, A=identity, B=rows {1..16}, no bubbles -> c_out equals B; done at cycle 12.
REQ-040 Scenario: row_cfg=2, col_cfg=3, k_len=5, all operands 1 -> c[i][j]=5 for i<2 and j<3, else 0; done at cycle 10.
REQ-041 Scenario: as REQ-039 with in_valid low every other cycle (3 bubbles) -> identical c_out; done at cycle 15.
REQ-042 Scenario: k_len=0 -> done and out_valid at cycle 1, c_out all zero, in_ready never high.
REQ-043 Scenario: rst_n low asynchronously at beat 2 of LOAD -> all outputs 0 before the next clk edge, no done; a following k_len=1 job of 2*3 -> every active c=6.
REQ-044 Scenario: WACC=16, k_len=3, all operands 127 -> 32767 with SA_SATURATE_EN, -17149 without.
